lattice_vector_serializer: RTL

Converts one VECTOR-wide pair of lattice state registers (a and b lanes, as produced by the per-stage delay registers) into a one-lane-per-cycle stream with valid/ready handshake. It sits at the consumer side of the delay stage and feeds narrow downstream logic (debug capture, coefficient-update MAC, output formatter) that handles one sample pair at a time. It sustains full throughput of one vector every VECTOR cycles with no bubbles, and applies backpressure to the vector producer.

---
 rtl/lattice_vector_serializer_pkg.sv | 19 +
 rtl/lattice_vector_serializer_if.sv | 36 +++
 rtl/lattice_vector_serializer.sv | 81 ++++++++
 3 files changed

// File: rtl/lattice_vector_serializer_pkg.sv
// Shared lattice types: sample width, FSM states, lane index width.
// Imported by the delay stage and the vector serializer.
package lattice_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_VECTOR    = 2;

  typedef logic [DEF_REG_WIDTH-1:0] sample_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int lane_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lattice_vector_serializer_if.sv
// Vector-in / sample-out handshake bundle for the serializer.
// master: producer+consumer side, slave: serializer side.
interface lattice_vector_serializer_if
  import lattice_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR
);

  localparam int LANE_W = lane_w(VECTOR);

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] a_in [VECTOR];
  logic [REG_WIDTH-1:0] b_in [VECTOR];

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] a_out;
  logic [REG_WIDTH-1:0] b_out;
  logic [LANE_W-1:0]    out_lane;
  logic                 out_last;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, a_out, b_out,
    input  out_lane, out_last
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, a_out, b_out,
    output out_lane, out_last
  );

endinterface

// File: rtl/lattice_vector_serializer.sv
// Serializes a VECTOR-wide a/b pair into one lane per beat.
// Reloads on the last beat so vectors stream without bubbles.
module lattice_vector_serializer
  import lattice_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR
) (
  input logic                       clk,
  input logic                       rst_n,
  lattice_vector_serializer_if.slave bus
);

  localparam int LANE_W = lane_w(VECTOR);
  localparam logic [LANE_W-1:0] LAST_LANE =
    LANE_W'(VECTOR - 1);

  state_t               r_state;
  logic [LANE_W-1:0]    r_lane;
  logic [REG_WIDTH-1:0] r_a_buf [VECTOR];
  logic [REG_WIDTH-1:0] r_b_buf [VECTOR];

  logic w_send;
  logic w_is_last;
  logic w_fire;

  assign w_send    = (r_state == SEND);
  assign w_is_last = (r_lane == LAST_LANE);
  assign w_fire    = w_send & bus.out_ready;

  assign bus.out_valid = w_send;
  assign bus.out_last  = w_send & w_is_last;
  assign bus.out_lane  = r_lane;
  assign bus.a_out     = r_a_buf[r_lane];
  assign bus.b_out     = r_b_buf[r_lane];

  // out_ready -> in_ready is combinational so the
  // next vector loads on the last beat with no bubble.
  assign bus.in_ready = (r_state == IDLE) |
                        (bus.out_last & bus.out_ready);

  // Lane counter, buffer capture and IDLE/SEND control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lane  <= '0;
      for (int i = 0; i < VECTOR; i++) begin
        r_a_buf[i] <= '0;
        r_b_buf[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_buf <= bus.a_in;
            r_b_buf <= bus.b_in;
            r_lane  <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_fire) begin
            if (w_is_last) begin
              r_lane <= '0;
              if (bus.in_valid) begin
                r_a_buf <= bus.a_in;
                r_b_buf <= bus.b_in;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
